reg17_shift_ctrl: RTL and testbench

Sequencer and serial capture stage for the 17-bit shift register that holds the adder result (carry plus 16-bit sum). On a Run request it pulses Load, then drives exactly N Shift_En cycles. While shifting it captures the register's serial Shift_Out stream, LSB first, into a parallel capture register, and optionally feeds each bit back so the source register is restored. Done flags a complete, valid capture.

---
 rtl/reg17_shift_ctrl.sv | 109 ++++++++++
 tb/tb_reg17_shift_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reg17_shift_ctrl.sv
// Load/shift sequencer for the 17-bit result register: pulses Load, drives N
// Shift_En cycles and deserialises the LSB-first Shift_Out stream into Captured.
module reg17_shift_ctrl #(
    parameter int N      = 17,
    parameter bit ROTATE = 1'b1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Run,
    input  logic                     Ser_In,
    output logic                     Load,
    output logic                     Shift_En,
    output logic                     Shift_In,
    output logic                     Busy,
    output logic                     Done,
    output logic [$clog2(N+1)-1:0]   Count,
    output logic [N-1:0]             Captured
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] FULL = CW'(N);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic            run_q, run_d;
    logic [CW-1:0]   count_q, count_d;
    logic [N-1:0]    captured_q, captured_d;
    logic            load_q, load_d;
    logic            shift_en_q, shift_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d    = state_q;
        run_d      = Run;
        count_d    = count_q;
        captured_d = captured_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (Run && !run_q) begin
                    state_d    = LOAD;
                    captured_d = '0;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                count_d = '0;
            end
            SHIFT: begin
                // Ser_In is the register's bit 0 before this edge's shift.
                captured_d = {Ser_In, captured_q[N-1:1]};
                count_d    = count_q + 1'b1;
                if (count_q == LAST)
                    state_d = DONE;
            end
            DONE: begin
                count_d = FULL;
                if (!Run) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes come straight from flops keyed on the next state, so they
    // change only at the clock edge and carry no decode glitches.
    always_comb begin
        load_d     = (state_d == LOAD);
        shift_en_d = (state_d == SHIFT);
        busy_d     = (state_d == LOAD) || (state_d == SHIFT);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            count_q    <= '0;
            captured_q <= '0;
            load_q     <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            count_q    <= count_d;
            captured_q <= captured_d;
            load_q     <= load_d;
            shift_en_q <= shift_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Load     = load_q;
    assign Shift_En = shift_en_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Count    = count_q;
    assign Captured = captured_q;
    assign Shift_In = ROTATE ? Ser_In : 1'b0;

endmodule

// File: tb/tb_reg17_shift_ctrl.sv
// Drives a rotating and a zero-fill instance, each wired to a 17-bit shift
// register model loaded from a shared word, and checks timing and capture.
module tb_reg17_shift_ctrl;

    localparam int N  = 17;
    localparam int CW = $clog2(N + 1);

    logic          Clk   = 1'b0;
    logic          Reset = 1'b0;
    logic          Run   = 1'b0;
    logic [N-1:0]  d     = '0;

    logic          load_r, se_r, shin_r, busy_r, done_r;
    logic          load_z, se_z, shin_z, busy_z, done_z;
    logic [CW-1:0] cnt_r, cnt_z;
    logic [N-1:0]  cap_r, cap_z;
    logic [N-1:0]  sr_r = '0, sr_z = '0;

    int total = 0;
    int bad   = 0;
    int shifts_r, shifts_z;

    always #5 Clk = ~Clk;

    reg17_shift_ctrl #(.N(N), .ROTATE(1'b1)) u_rot (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Ser_In(sr_r[0]),
        .Load(load_r), .Shift_En(se_r), .Shift_In(shin_r), .Busy(busy_r),
        .Done(done_r), .Count(cnt_r), .Captured(cap_r)
    );

    reg17_shift_ctrl #(.N(N), .ROTATE(1'b0)) u_zero (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Ser_In(sr_z[0]),
        .Load(load_z), .Shift_En(se_z), .Shift_In(shin_z), .Busy(busy_z),
        .Done(done_z), .Count(cnt_z), .Captured(cap_z)
    );

    // The 17-bit shift registers being sequenced (D tied to d).
    always @(posedge Clk) begin
        if (load_r) sr_r <= d;
        else if (se_r) sr_r <= {shin_r, sr_r[N-1:1]};
        if (load_z) sr_z <= d;
        else if (se_z) sr_z <= {shin_z, sr_z[N-1:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".load"}, 32'(load_r), 0); chk({tag, ".load_z"}, 32'(load_z), 0);
        chk({tag, ".se"},   32'(se_r), 0);   chk({tag, ".se_z"},   32'(se_z), 0);
        chk({tag, ".busy"}, 32'(busy_r), 0); chk({tag, ".busy_z"}, 32'(busy_z), 0);
        chk({tag, ".done"}, 32'(done_r), 0); chk({tag, ".done_z"}, 32'(done_z), 0);
        chk({tag, ".cnt"},  32'(cnt_r), 0);  chk({tag, ".cnt_z"},  32'(cnt_z), 0);
    endtask

    // k = cycles since the edge that sampled the start (k=1 is the Load cycle).
    task automatic chk_cycle(input int k);
        logic e_load, e_se, e_busy, e_done;
        int   e_cnt;
        e_load = (k == 1);
        e_se   = (k >= 2) && (k <= N + 1);
        e_busy = (k <= N + 1);
        e_done = (k >= N + 2);
        e_cnt  = (k == 1) ? 0 : (k <= N + 1) ? k - 2 : N;
        chk("load", 32'(load_r), 32'(e_load)); chk("load_z", 32'(load_z), 32'(e_load));
        chk("se",   32'(se_r),   32'(e_se));   chk("se_z",   32'(se_z),   32'(e_se));
        chk("busy", 32'(busy_r), 32'(e_busy)); chk("busy_z", 32'(busy_z), 32'(e_busy));
        chk("done", 32'(done_r), 32'(e_done)); chk("done_z", 32'(done_z), 32'(e_done));
        chk("cnt",  32'(cnt_r),  e_cnt);       chk("cnt_z",  32'(cnt_z),  e_cnt);
    endtask

    // mode 0: one-cycle Run pulse; 1: Run held 40 cycles; 2: random Run
    // toggles while shifting. abort_k > 0 asserts Reset mid-cycle at that k.
    task automatic run_seq(input logic [N-1:0] dw, input int mode, input int abort_k);
        int kmax;
        d = dw;
        shifts_r = 0;
        shifts_z = 0;
        Run = 1'b1;
        kmax = (mode == 1) ? 40 : N + 2;
        for (int k = 1; k <= kmax; k++) begin
            step();
            if (k == abort_k) begin
                #2 Reset = 1'b1;
                #1;
                chk_quiet("async_rst");
                chk("async_rst.cap", 32'(cap_r), 0);
                chk("async_rst.cap_z", 32'(cap_z), 0);
                Run = 1'b0;
                step(); step();
                Reset = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    step();
                    chk_quiet("post_rst_idle");
                end
                return;
            end
            chk_cycle(k);
            shifts_r += int'(se_r);
            shifts_z += int'(se_z);
            if (k == 1) begin
                chk("cap_clear", 32'(cap_r), 0);
                chk("cap_clear_z", 32'(cap_z), 0);
            end
            case (mode)
                0:       Run = 1'b0;
                1:       Run = (k < 40);
                default: Run = (k < N) ? 1'($urandom_range(0, 1)) : 1'b0;
            endcase
        end
        chk("shift_cycles", shifts_r, N);
        chk("shift_cycles_z", shifts_z, N);
        chk("captured", 32'(cap_r), 32'(dw));
        chk("captured_z", 32'(cap_z), 32'(dw));
        chk("sr_restored", 32'(sr_r), 32'(dw));
        chk("sr_zeroed", 32'(sr_z), 0);
        step();
        chk_quiet("back_idle");
        chk("cap_held", 32'(cap_r), 32'(dw));
        chk("cap_held_z", 32'(cap_z), 32'(dw));
    endtask

    initial begin
        #1 Reset = 1'b1;
        #2;
        chk_quiet("reset");
        chk("reset.cap", 32'(cap_r), 0);
        step(); step();
        Reset = 1'b0;
        step();
        chk_quiet("idle");

        run_seq(17'h1_2345, 0, 0);
        run_seq(17'h1_FFFF, 0, 0);
        run_seq(17'h0_AAAA, 1, 0);
        run_seq(17'h0_5555, 0, 0);
        run_seq(17'h1_0001, 2, 0);
        run_seq(17'h0_0000, 0, 0);
        run_seq(17'h1_6C3A, 0, 10);
        run_seq(17'h0_F00F, 0, 0);

        for (int i = 0; i < 8; i++)
            run_seq(N'($urandom), $urandom_range(0, 2), 0);

        // Run already high when Reset releases counts as a start.
        Run = 1'b1;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        chk("rst_release_start", 32'(load_r), 1);
        chk("rst_release_start_z", 32'(load_z), 1);
        Run = 1'b0;
        repeat (N + 3) step();
        chk_quiet("rst_release_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
